// File: rtl/skill_ctrl.sv
// Skill controller: edge-detected skill requests spend points from a regenerating pool,
// and each fired skill stays active for a fixed number of game ticks.
module skill_ctrl #(
  parameter int NUM_SKILLS     = 3,
  parameter int MAX_POINTS     = 3,
  parameter int INIT_POINTS    = 0,
  parameter int REGEN_TICKS    = 200,
  parameter int DURATION_TICKS = 100,
  localparam int PW            = $clog2(MAX_POINTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  enable,
  input  logic                  new_game,
  input  logic [NUM_SKILLS-1:0] skill_req,
  output logic [NUM_SKILLS-1:0] skill_active,
  output logic [NUM_SKILLS-1:0] skill_fire,
  output logic [PW-1:0]         points,
  output logic [MAX_POINTS-1:0] point_bar
);

  localparam int CMAX = (REGEN_TICKS > DURATION_TICKS) ? REGEN_TICKS : DURATION_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  logic [NUM_SKILLS-1:0] req_q;
  logic [NUM_SKILLS-1:0] active_q, active_d;
  logic [CW-1:0]         dur_q [NUM_SKILLS];
  logic [CW-1:0]         dur_d [NUM_SKILLS];
  logic [CW-1:0]         regen_q, regen_d;
  logic [PW-1:0]         points_q, points_d;
  logic [NUM_SKILLS-1:0] cand, fire;
  logic                  found, regen_hit;
  logic [PW:0]           pool_sum;

  // Lowest-index eligible rising edge wins; everything else is dropped, not queued.
  always_comb begin
    cand  = skill_req & ~req_q & ~active_q;
    fire  = '0;
    found = 1'b0;
    if (enable && (points_q != '0)) begin
      for (int i = 0; i < NUM_SKILLS; i++) begin
        if (cand[i] && !found) begin
          fire[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    regen_d   = regen_q;
    regen_hit = 1'b0;
    if (!enable) begin
      regen_d = '0;
    end else if (tick) begin
      if (regen_q == CW'(REGEN_TICKS - 1)) begin
        regen_d   = '0;
        regen_hit = 1'b1;
      end else begin
        regen_d = regen_q + CW'(1);
      end
    end
    // A fire needs points > 0, so the subtraction cannot go below zero.
    pool_sum = {1'b0, points_q} + (PW + 1)'(regen_hit) - (PW + 1)'(found);
    if (pool_sum > (PW + 1)'(MAX_POINTS)) begin
      points_d = PW'(MAX_POINTS);
    end else begin
      points_d = pool_sum[PW-1:0];
    end
    if (new_game) begin
      regen_d  = '0;
      points_d = PW'(INIT_POINTS);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SKILLS; i++) begin
      active_d[i] = active_q[i];
      dur_d[i]    = dur_q[i];
      if (!enable || new_game) begin
        active_d[i] = 1'b0;
        dur_d[i]    = '0;
      end else if (fire[i]) begin
        active_d[i] = 1'b1;
        dur_d[i]    = CW'(DURATION_TICKS);
      end else if (active_q[i] && tick) begin
        if (dur_q[i] == CW'(1)) begin
          active_d[i] = 1'b0;
          dur_d[i]    = '0;
        end else begin
          dur_d[i] = dur_q[i] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q    <= '0;
      active_q <= '0;
      regen_q  <= '0;
      points_q <= PW'(INIT_POINTS);
      for (int i = 0; i < NUM_SKILLS; i++) dur_q[i] <= '0;
    end else begin
      req_q    <= skill_req;
      active_q <= active_d;
      regen_q  <= regen_d;
      points_q <= points_d;
      for (int i = 0; i < NUM_SKILLS; i++) dur_q[i] <= dur_d[i];
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_POINTS; k++) point_bar[k] = (int'(points_q) > k);
  end

  assign skill_fire   = fire;
  assign skill_active = active_q;
  assign points       = points_q;

endmodule
